// File: rtl/mem_port_scheduler.sv
// mem_port_scheduler
// Shares the single data-memory port between issued loads and committed
// stores draining from the store buffer head. One request owns the port
// from grant until the memory answers. Loads are squashable by flush;
// stores are not. A starvation counter forces a waiting store through
// after STARVE_LIMIT consecutive load grants.
// Optional build macro: MEM_SCHED_PERF_EN adds grant and busy-cycle
// performance counters as extra output ports.

module mem_port_scheduler #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  ld_req_valid,
    input  logic [ADDR_W-1:0]     ld_req_addr,
    input  logic [TAG_W-1:0]      ld_req_tag,
    output logic                  ex_busy,
    input  logic                  st_req_valid,
    input  logic [ADDR_W-1:0]     st_req_addr,
    input  logic [DATA_W-1:0]     st_req_data,
    input  logic [DATA_W/8-1:0]   st_req_strb,
    output logic                  st_req_ready,
    output logic                  mem_req_valid,
    output logic                  mem_req_we,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_strb,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [DATA_W-1:0]     mem_resp_data,
    output logic                  ld_resp_valid,
    output logic [TAG_W-1:0]      ld_resp_tag,
    output logic [DATA_W-1:0]     ld_resp_data
`ifdef MEM_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_ld_grants,
    output logic [31:0]           perf_st_grants,
    output logic [31:0]           perf_port_busy_cycles
`endif
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIMIT);

    logic [1:0]        state_r;
    logic [3:0]        starve_cnt_r;
    logic              squash_r;
    logic              mem_req_valid_r;
    logic              req_we_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic [DATA_W-1:0] req_wdata_r;
    logic [STRB_W-1:0] req_strb_r;
    logic [TAG_W-1:0]  req_tag_r;
    logic              ld_resp_valid_r;
    logic [TAG_W-1:0]  ld_resp_tag_r;
    logic [DATA_W-1:0] ld_resp_data_r;

    logic              idle_s;
    logic              st_win_s;
    logic              ld_win_s;
    logic              ex_busy_s;
    logic              ld_squash_s;

    // Arbitration in IDLE and back-pressure towards the load issue queue
    always_comb begin
        idle_s      = (state_r == ST_IDLE);
        st_win_s    = 1'b0;
        ld_win_s    = 1'b0;
        if (idle_s && st_req_valid &&
            (!ld_req_valid || (starve_cnt_r == STARVE_LIM_C))) begin
            st_win_s = 1'b1;
        end else if (idle_s && ld_req_valid && !flush) begin
            ld_win_s = 1'b1;
        end else begin
            st_win_s = 1'b0;
            ld_win_s = 1'b0;
        end
        // A load cannot be taken while the port is owned, while flushing,
        // or while a store is taking the port this cycle.
        ex_busy_s   = !idle_s || flush || st_win_s;
        // Flush only affects a load that currently owns the port.
        ld_squash_s = flush && !req_we_r;
    end

    // Port FSM, request latches, starvation counter and load response
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            starve_cnt_r    <= 4'd0;
            squash_r        <= 1'b0;
            mem_req_valid_r <= 1'b0;
            req_we_r        <= 1'b0;
            req_addr_r      <= '0;
            req_wdata_r     <= '0;
            req_strb_r      <= '0;
            req_tag_r       <= '0;
            ld_resp_valid_r <= 1'b0;
            ld_resp_tag_r   <= '0;
            ld_resp_data_r  <= '0;
        end else begin
            ld_resp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (st_win_s) begin
                        state_r         <= ST_REQ;
                        mem_req_valid_r <= 1'b1;
                        req_we_r        <= 1'b1;
                        req_addr_r      <= st_req_addr;
                        req_wdata_r     <= st_req_data;
                        req_strb_r      <= st_req_strb;
                        req_tag_r       <= '0;
                        starve_cnt_r    <= 4'd0;
                    end else if (ld_win_s) begin
                        state_r         <= ST_REQ;
                        mem_req_valid_r <= 1'b1;
                        req_we_r        <= 1'b0;
                        req_addr_r      <= ld_req_addr;
                        req_wdata_r     <= '0;
                        req_strb_r      <= '0;
                        req_tag_r       <= ld_req_tag;
                        if (st_req_valid && (starve_cnt_r != 4'hF)) begin
                            starve_cnt_r <= starve_cnt_r + 4'd1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        // Already accepted: a flushed load must still drain.
                        state_r         <= ST_WAIT;
                        mem_req_valid_r <= 1'b0;
                        squash_r        <= ld_squash_s;
                    end else if (ld_squash_s) begin
                        state_r         <= ST_IDLE;
                        mem_req_valid_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        state_r  <= ST_IDLE;
                        squash_r <= 1'b0;
                        if (!req_we_r && !squash_r && !flush) begin
                            ld_resp_valid_r <= 1'b1;
                            ld_resp_tag_r   <= req_tag_r;
                            ld_resp_data_r  <= mem_resp_data;
                        end
                    end else if (ld_squash_s) begin
                        squash_r <= 1'b1;
                    end
                end
                default: begin
                    state_r         <= ST_IDLE;
                    mem_req_valid_r <= 1'b0;
                    squash_r        <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_SCHED_PERF_EN
    logic [31:0] perf_ld_grants_r;
    logic [31:0] perf_st_grants_r;
    logic [31:0] perf_busy_r;

    // Wrapping performance counters for grants and port occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ld_grants_r <= 32'd0;
            perf_st_grants_r <= 32'd0;
            perf_busy_r      <= 32'd0;
        end else begin
            if (ld_win_s) begin
                perf_ld_grants_r <= perf_ld_grants_r + 32'd1;
            end
            if (st_win_s) begin
                perf_st_grants_r <= perf_st_grants_r + 32'd1;
            end
            if (!idle_s) begin
                perf_busy_r <= perf_busy_r + 32'd1;
            end
        end
    end

    assign perf_ld_grants        = perf_ld_grants_r;
    assign perf_st_grants        = perf_st_grants_r;
    assign perf_port_busy_cycles = perf_busy_r;
`endif

    assign ex_busy       = ex_busy_s;
    assign st_req_ready  = st_win_s;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_we    = req_we_r;
    assign mem_req_addr  = req_addr_r;
    assign mem_req_wdata = req_wdata_r;
    assign mem_req_strb  = req_strb_r;
    assign ld_resp_valid = ld_resp_valid_r;
    assign ld_resp_tag   = ld_resp_tag_r;
    assign ld_resp_data  = ld_resp_data_r;

endmodule

// File: doc/mem_port_scheduler.md
Name: mem_port_scheduler

Overview:
- Sequences the single data-memory port shared by loads issued from the memory issue queue and committed stores draining from the store buffer head.
- Grants one request at a time, holds it until the memory side accepts and answers, and returns load data with its tag.
- Back-pressures the memory issue queue through ex_busy.
- Sits between the memory issue queue / PRF read stage and the D-cache interface.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width; strobe width is DATA_W/8
- TAG_W, 6, load tag width (destination PRF index)
- STARVE_LIMIT, 4, consecutive load grants with a store waiting before the store is forced to win; legal 1..15

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; squashes loads, never stores
- ld_req_valid  in  1  issued load present
- ld_req_addr  in  ADDR_W  load address
- ld_req_tag  in  TAG_W  load tag
- ex_busy  out  1  1 = load not accepted this cycle (feeds the issue queue's ex_busy)
- st_req_valid  in  1  committed store at store buffer head
- st_req_addr  in  ADDR_W  store address
- st_req_data  in  DATA_W  store data
- st_req_strb  in  DATA_W/8  byte strobes
- st_req_ready  out  1  store accepted this cycle
- mem_req_valid  out  1  request to memory
- mem_req_we  out  1  1 = store
- mem_req_addr  out  ADDR_W  request address
- mem_req_wdata  out  DATA_W  write data
- mem_req_strb  out  DATA_W/8  write strobes; all zero for loads
- mem_req_ready  in  1  memory accepts the request
- mem_resp_valid  in  1  memory response (read data or write ack)
- mem_resp_data  in  DATA_W  read data
- ld_resp_valid  out  1  load result valid, 1-cycle pulse
- ld_resp_tag  out  TAG_W  tag of the returned load
- ld_resp_data  out  DATA_W  returned load data

Behaviour:
- FSM states: IDLE, REQ, WAIT. Reset puts the FSM in IDLE and clears every output register, the starve counter and the squash bit. After reset: ex_busy=1 for one cycle only if IDLE is blocked (see below), otherwise ex_busy=0; all other outputs 0.
- Arbitration happens only in IDLE. The store wins if st_req_valid and (ld_req_valid=0 or starve_cnt==STARVE_LIMIT); otherwise the load wins if ld_req_valid and flush=0.
- Outside IDLE: ex_busy=1 and st_req_ready=0. In IDLE, ex_busy=1 whenever the load does not win; flush in IDLE forces ex_busy=1.
- A grant latches addr, data, strobe, tag and type into registers and moves the FSM to REQ. mem_req_* is driven from these registers only; nothing passes combinationally from requesters to memory.
- REQ: mem_req_valid=1, all fields held stable until mem_req_ready=1, then move to WAIT.
- WAIT: on mem_resp_valid, return to IDLE next cycle. For a non-squashed load, register ld_resp_valid=1 with ld_resp_tag and ld_resp_data, visible the cycle after mem_resp_valid.
- Latency, zero-wait memory (mem_req_ready=1 in REQ, response the next cycle): grant at cycle N, mem_req_valid at N+1, response at N+2, ld_resp_valid at N+3, next grant possible at N+3.
- starve_cnt, 4-bit saturating:
  - increments when a load wins while st_req_valid=1;
  - clears when a store wins;
  - holds otherwise.
- flush with a load in REQ and mem_req_ready=0: cancel; mem_req_valid drops next cycle, FSM goes to IDLE.
- flush with a load in REQ and mem_req_ready=1 in the same cycle: the request is already accepted; go to WAIT with the squash bit set.
- flush with a load in WAIT: set the squash bit. The response is consumed, ld_resp_valid stays 0, and the squash bit clears on return to IDLE.
- flush during a store has no effect.
- mem_resp_valid outside WAIT is ignored.
- Reset mid-transaction aborts it and returns to IDLE with no response pulse. The memory side is reset by the same signal.

Optional Feature:
- MEM_SCHED_PERF_EN adds 32-bit wrapping output ports perf_ld_grants, perf_st_grants and perf_port_busy_cycles (cycles with FSM != IDLE). All three clear on reset.
- Without the macro these ports and their counters do not exist.

Test Plan:
- Load only, zero-wait memory: ld_req_valid at cycle 0 with addr=0x100, tag=5; memory returns 0xDEADBEEF -> mem_req_valid at cycle 1, ld_resp_valid at cycle 3 with tag=5, data=0xDEADBEEF.
- Store only: st_req_valid with addr=0x200, data=0x12345678, strb=0xF -> st_req_ready at cycle 0, mem_req_we=1 at cycle 1, no ld_resp_valid.
- Load and store valid every cycle, STARVE_LIMIT=4 -> grant order L,L,L,L,S,L,L,L,L,S; ex_busy=1 in each store-grant cycle.
- mem_req_ready held 0 for 5 cycles -> mem_req_* stable across all 5 cycles, ex_busy=1 throughout.
- flush while a load is in WAIT, then mem_resp_valid -> no ld_resp_valid pulse; FSM in IDLE and a new load accepted the following cycle.
- flush in REQ with mem_req_ready=0 -> mem_req_valid=0 next cycle; a store issued during flush completes normally.
